line_buf_writer: RTL

Write-side companion of the convolution layer. It accepts the three per-kernel result streams (`result_0..2`, qualified by `de_in`) and requantizes each to `BIT_DEPTH` bits. It packs them into one `BIT_DEPTH*3` word and writes the rows round-robin into four line-buffer RAMs. It raises `start_rd` once three full rows are stored, so the next convolution layer can read three banks while the fourth is being filled.

---
 rtl/line_buf_writer_pkg.sv | 20 ++
 rtl/lbw_quant.sv | 44 ++++
 rtl/line_buf_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/line_buf_writer_pkg.sv
// line_buf_writer shared types: FSM states, bank count, pixel packing.
// Shared by line_buf_writer and lbw_quant.
package line_buf_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    WAIT_ACK
  } lbw_state_e;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int NUM_CH    = 3;

  function automatic int pix_width(input int bd);
    return bd * NUM_CH;
  endfunction

endpackage

// File: rtl/lbw_quant.sv
// One-channel requantizer: arithmetic shift, then saturate.
// LBW_RELU_EN selects unsigned ReLU clamp instead of signed clamp.
module lbw_quant
  import line_buf_writer_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int RES_W     = 21,
  parameter int SHIFT     = 0
) (
  input  logic signed [RES_W-1:0]     r,
  output logic        [BIT_DEPTH-1:0] q
);

  logic signed [RES_W-1:0] s;

  assign s = r >>> SHIFT;

`ifdef LBW_RELU_EN
  localparam int MAXI = (1 << BIT_DEPTH) - 1;
  localparam logic signed [RES_W-1:0] MAXV = RES_W'(MAXI);

  always_comb begin
    q = s[BIT_DEPTH-1:0];
    if (s < 0)
      q = '0;
    else if (s > MAXV)
      q = '1;
  end
`else
  localparam int MAXI = (1 << (BIT_DEPTH - 1)) - 1;
  localparam int MINI = -(1 << (BIT_DEPTH - 1));
  localparam logic signed [RES_W-1:0] MAXV = RES_W'(MAXI);
  localparam logic signed [RES_W-1:0] MINV = RES_W'(MINI);

  always_comb begin
    q = s[BIT_DEPTH-1:0];
    if (s > MAXV)
      q = {1'b0, {(BIT_DEPTH-1){1'b1}}};
    else if (s < MINV)
      q = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  end
`endif

endmodule

// File: rtl/line_buf_writer.sv
// Requantize three conv result streams and write rows round-robin
// into four line-buffer banks. Optional macro: LBW_RELU_EN.
module line_buf_writer
  import line_buf_writer_pkg::*;
#(
  parameter int          BIT_DEPTH    = 8,
  parameter int          RES_W        = 21,
  parameter logic [10:0] IMAGE_WIDTH  = 11'd26,
  parameter logic [10:0] IMAGE_HEIGHT = 11'd26,
  parameter int          SHIFT        = 0
) (
  input  logic                              clk,
  input  logic                              RESET,
  input  logic                              de_in,
  input  logic signed [RES_W-1:0]           result_0,
  input  logic signed [RES_W-1:0]           result_1,
  input  logic signed [RES_W-1:0]           result_2,
  input  logic                              frame_ack,
  output logic [10:0]                       out_addr,
  output logic                              out0_wren,
  output logic                              out1_wren,
  output logic                              out2_wren,
  output logic                              out3_wren,
  output logic [pix_width(BIT_DEPTH)-1:0]   out_data,
  output logic                              start_rd,
  output logic                              frame_done,
  output logic                              err_len,
  output logic                              err_ovr
);

  lbw_state_e                         state;
  logic [10:0]                        col;
  logic [10:0]                        row_cnt;
  logic                               de_d;
  logic [NUM_BANKS-1:0]               wren;
  logic [BIT_DEPTH-1:0]               q0, q1, q2;
  logic [pix_width(BIT_DEPTH)-1:0]    pix;
  logic                               last_row;
  logic                               fill_done;

  lbw_quant #(.BIT_DEPTH(BIT_DEPTH), .RES_W(RES_W), .SHIFT(SHIFT))
    u_q0 (.r(result_0), .q(q0));
  lbw_quant #(.BIT_DEPTH(BIT_DEPTH), .RES_W(RES_W), .SHIFT(SHIFT))
    u_q1 (.r(result_1), .q(q1));
  lbw_quant #(.BIT_DEPTH(BIT_DEPTH), .RES_W(RES_W), .SHIFT(SHIFT))
    u_q2 (.r(result_2), .q(q2));

  assign pix = {q0, q1, q2};

  // A 3-row frame ends in FILL, so last_row must win over fill_done
  assign last_row  = (state == FILL || state == STREAM) &&
                     (row_cnt == IMAGE_HEIGHT - 11'd1);
  assign fill_done = (state == FILL) && (row_cnt == 11'd2) &&
                     !last_row;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      col        <= '0;
      row_cnt    <= '0;
      de_d       <= 1'b0;
      wren       <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      start_rd   <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      wren       <= '0;
      frame_done <= 1'b0;
      // Dropped overrun data must not produce a row end later
      de_d       <= de_in && (state != WAIT_ACK);
      if (state == WAIT_ACK) begin
        if (de_in)
          err_ovr <= 1'b1;
        if (frame_ack) begin
          state    <= IDLE;
          start_rd <= 1'b0;
        end
      end else if (de_in) begin
        if (state == IDLE)
          state <= FILL;
        if (col == IMAGE_WIDTH) begin
          err_len <= 1'b1;
        end else begin
          out_data                  <= pix;
          out_addr                  <= col;
          wren[row_cnt[BANK_W-1:0]] <= 1'b1;
          col                       <= col + 11'd1;
        end
      end else if (de_d) begin
        col     <= '0;
        row_cnt <= row_cnt + 11'd1;
        if (col != IMAGE_WIDTH)
          err_len <= 1'b1;
        unique case (1'b1)
          last_row: begin
            frame_done <= 1'b1;
            start_rd   <= 1'b1;
            row_cnt    <= '0;
            state      <= WAIT_ACK;
          end
          fill_done: begin
            start_rd <= 1'b1;
            state    <= STREAM;
          end
          default: ;
        endcase
      end
    end
  end

  assign out0_wren = wren[0];
  assign out1_wren = wren[1];
  assign out2_wren = wren[2];
  assign out3_wren = wren[3];

endmodule
